// File: rtl/rv64_alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : rv64_alu_pkg                                           |
// | Brief   : Shared ALU/issue/writeback types and widths.           |
// | Rev     : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package rv64_alu_pkg;

    localparam int XLEN        = 64;
    localparam int ALU_OP_W    = 3;
    localparam int ISSUE_TAG_W = 5;

    typedef logic [XLEN-1:0]        xlen_t;
    typedef logic [ALU_OP_W-1:0]    alu_op_t;
    typedef logic [ISSUE_TAG_W-1:0] issue_tag_t;

    typedef struct packed {
        xlen_t      a;
        xlen_t      b;
        alu_op_t    op;
        issue_tag_t tag;
    } issue_entry_t;

endpackage
`default_nettype wire

// File: rtl/rv64_issue_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : rv64_issue_ram                                         |
// | Brief   : DEPTH x WIDTH register array, 1 write / 1 async read.  |
// | Rev     : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module rv64_issue_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 136
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    // Contents are never reset; the queue masks its outputs while empty.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/rv64_alu_issue_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : rv64_alu_issue_queue                                   |
// | Brief   : In-order operand FIFO feeding rv64_alu, with tags.     |
// | Rev     : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module rv64_alu_issue_queue
    import rv64_alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_a,
    input  logic [XLEN-1:0]         in_b,
    input  logic [ALU_OP_W-1:0]     in_op,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_a,
    output logic [XLEN-1:0]         out_b,
    output logic [ALU_OP_W-1:0]     out_op,
    output logic [TAG_W-1:0]        out_tag,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_ENTRY_W = 2 * XLEN + ALU_OP_W + TAG_W;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0]     a;
        logic [XLEN-1:0]     b;
        logic [ALU_OP_W-1:0] op;
        logic [TAG_W-1:0]    tag;
    } entry_t;

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic   w_push;
    logic   w_pop;
    logic   w_wr_en;
    entry_t w_wr_entry;
    entry_t w_head;

    // Both handshake qualifiers depend only on r_count, so no input reaches them.
    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_wr_en   = w_push && !flush && !rst;

    assign w_wr_entry = '{a: in_a, b: in_b, op: in_op, tag: in_tag};

    rv64_issue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (r_wr_ptr),
        .wr_data (w_wr_entry),
        .rd_addr (r_rd_ptr),
        .rd_data (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is unreset, so the head is masked to zero whenever the queue is empty.
    assign out_a   = out_valid ? w_head.a   : '0;
    assign out_b   = out_valid ? w_head.b   : '0;
    assign out_op  = out_valid ? w_head.op  : '0;
    assign out_tag = out_valid ? w_head.tag : '0;
    assign count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_rv64_alu_issue_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_rv64_alu_issue_queue                                |
// | Brief   : Directed scoreboard bench for rv64_alu_issue_queue.    |
// | Rev     : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_rv64_alu_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    typedef struct packed {
        logic [63:0]      a;
        logic [63:0]      b;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_a;
    logic [63:0]      in_b;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_a;
    logic [63:0]      out_b;
    logic [2:0]       out_op;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       count;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic zero_after_rst = 1'b0;

    logic [63:0]      hold_a;
    logic [63:0]      hold_b;
    logic [2:0]       hold_op;
    logic [TAG_W-1:0] hold_tag;

    always #5 clk = ~clk;

    rv64_alu_issue_queue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_op    (out_op),
        .out_tag   (out_tag),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_state();
        chk("count", 64'(count), 64'(q.size()));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
        if (q.size() != 0) begin
            chk("head_a", out_a, q[0].a);
            chk("head_b", out_b, q[0].b);
            chk("head_op", 64'(out_op), 64'(q[0].op));
            chk("head_tag", 64'(out_tag), 64'(q[0].tag));
        end else if (zero_after_rst) begin
            chk("empty_a", out_a, 64'd0);
            chk("empty_b", out_b, 64'd0);
            chk("empty_op", 64'(out_op), 64'd0);
            chk("empty_tag", 64'(out_tag), 64'd0);
        end
    endtask

    // Checks the state left by the previous edge, then drives one cycle of stimulus
    // and advances the reference queue by what that edge must do.
    task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] op, input logic [TAG_W-1:0] tag,
                        input logic rdy, input logic fl, input logic r);
        logic push;
        logic pop;
        @(negedge clk);
        check_state();
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_tag    = tag;
        out_ready = rdy;
        flush     = fl;
        rst       = r;
        push = v && (q.size() != DEPTH);
        pop  = rdy && (q.size() != 0);
        if (r) begin
            q.delete();
            zero_after_rst = 1'b1;
        end else if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back('{a: a, b: b, op: op, tag: tag});
                zero_after_rst = 1'b0;
            end
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 64'd0, 64'd0, 3'd0, '0, rdy, 1'b0, 1'b0);
    endtask

    task automatic push_one(input logic [2:0] op, input logic [TAG_W-1:0] tag, input logic rdy);
        step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, op, tag, rdy, 1'b0, 1'b0);
    endtask

    task automatic check_hold();
        chk("stall_a", out_a, hold_a);
        chk("stall_b", out_b, hold_b);
        chk("stall_op", 64'(out_op), 64'(hold_op));
        chk("stall_tag", 64'(out_tag), 64'(hold_tag));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        zero_after_rst = 1'b1;

        // Single push, observe next cycle, then pop.
        step(1'b1, 64'h210000000, 64'h100000000, 3'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill, reject a fifth, full-cycle pop-only, then drain.
        for (int i = 0; i < 4; i++) push_one(3'(i), 5'(10 + i), 1'b0);
        push_one(3'd7, 5'd31, 1'b0);
        push_one(3'd6, 5'd30, 1'b1);
        idle(1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        idle(1'b0);

        // Streaming with wrap-around.
        for (int i = 0; i < 20; i++) push_one(3'(i % 8), 5'(i), 1'b1);
        idle(1'b1);
        idle(1'b0);

        // Stall with head op 5.
        push_one(3'd5, 5'd21, 1'b0);
        push_one(3'd2, 5'd22, 1'b0);
        idle(1'b0);
        hold_a = out_a; hold_b = out_b; hold_op = out_op; hold_tag = out_tag;
        chk("stall_head_op", 64'(out_op), 64'd5);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            check_hold();
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // Flush together with a push at count 3.
        for (int i = 0; i < 3; i++) push_one(3'(i + 4), 5'(i + 24), 1'b0);
        step(1'b1, 64'hdead, 64'hbeef, 3'd7, 5'd27, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        push_one(3'd1, 5'd3, 1'b0);
        idle(1'b1);

        // Reset mid-stream together with a push.
        push_one(3'd3, 5'd4, 1'b0);
        push_one(3'd4, 5'd5, 1'b0);
        step(1'b1, 64'h1234, 64'h5678, 3'd6, 5'd6, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv64_alu_issue_queue.md
# rv64_alu_issue_queue

Operand issue queue sitting directly upstream of the combinational `rv64_alu`. Buffers `{a, b, op, tag}` requests from decode in a small in-order FIFO and presents the head entry, from registers, on the ALU's `a`/`b`/`op` inputs under a valid/ready handshake. Decouples decode from execute back-pressure and carries a tag so writeback can match each result to its request.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `TAG_W`, 5: width of the request tag.

Ports:
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `flush`  in  1: synchronous discard of all entries.
- `in_valid`  in  1: request present.
- `in_ready`  out  1: queue can accept a request this cycle.
- `in_a`  in  64: operand A.
- `in_b`  in  64: operand B.
- `in_op`  in  3: ALU op code, 0–7, passed through unmodified.
- `in_tag`  in  TAG_W: request tag.
- `out_valid`  out  1: head entry is valid.
- `out_ready`  in  1: downstream consumes the head this cycle.
- `out_a`  out  64: to ALU `a`.
- `out_b`  out  64: to ALU `b`.
- `out_op`  out  3: to ALU `op`.
- `out_tag`  out  TAG_W: tag travelling alongside the ALU result.
- `count`  out  $clog2(DEPTH)+1: current occupancy.

## Operation
- Push: `in_valid && in_ready`. Writes the entry at `wr_ptr`; `wr_ptr` increments modulo DEPTH.
- Pop: `out_valid && out_ready`. `rd_ptr` increments modulo DEPTH.
- `in_ready` = `count != DEPTH`, a function of registered state only.
  - No pass-through when full: if full and popping in the same cycle, `in_ready` is still 0.
- `out_valid` = `count != 0`.
- `out_a/out_b/out_op/out_tag` are the head entry read from storage; all are registered outputs.
- Push and pop in the same cycle: `count` unchanged, both pointers advance.
- Empty-cycle push: the entry appears at the outputs on the next cycle. There is no same-cycle bypass.
- Stall: while `out_valid && !out_ready`, all `out_*` signals hold stable.
- Ordering: strict FIFO. Ops and tags are never reordered, altered or checked; all 8 op codes are legal.
- `flush`:
  - Next cycle: `count` = 0 and `rd_ptr` = `wr_ptr` = 0.
  - Any push or pop in the flush cycle is discarded.
  - `flush` overrides both handshakes.
- `rst` has priority over `flush`.
  - Reset values: `count` = 0, pointers = 0, `out_valid` = 0, `in_ready` = 1, `out_a` = `out_b` = 0, `out_op` = 0, `out_tag` = 0.
  - Storage contents need not be reset, but `out_*` must read 0 while empty after reset.
- Reset or flush mid-operation drops all in-flight entries. No partial state survives.

## Timing
- Latency, empty queue: push at edge N → `out_valid` = 1 with that entry from edge N+1 onward.
- Throughput: one push and one pop per cycle sustained when `0 < count < DEPTH`.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble.
- `count` transitions:
  - push only: +1
  - pop only: −1
  - both or neither: unchanged
  - flush/rst: 0
- Combinational paths: none from `in_*` to `out_*`, and none from `out_ready` to `in_ready`.

## Structure
- Shared package `rv64_alu_pkg`:
  - `XLEN` = 64
  - `ALU_OP_W` = 3
  - issue-entry typedef `{a, b, op, tag}`
  - this package is shared with `rv64_alu` and writeback
- One sub-module: `rv64_issue_ram`, a DEPTH × entry register array with one write port and one asynchronous read port at `rd_ptr`.
- Pointer/count control stays in the top module.

## Test plan
- Reset then single push `a=64'h210000000`, `b=64'h100000000`, `op=3'd0`, `tag=1` → next cycle `out_valid=1` with the same fields and `count=1`; pop → `out_valid=0`, `count=0`.
- Push 4 entries with ops 0..3 and `out_ready=0` → `in_ready=0`, `count=4`. A 5th `in_valid` is not accepted. Draining yields ops 0,1,2,3 and tags in order.
- Full queue with `in_valid=1` and `out_ready=1` in the same cycle → pop only: `count=3`, and `in_ready=1` on the next cycle.
- Continuous streaming of 20 pushes with `out_ready=1`, ops cycling 0..7 → one result per cycle after the first, correct wrap, `count` steady at 1.
- `out_ready` held 0 for 3 cycles with the head at `op=3'd5` → `out_*` bit-stable across the stall; it advances on the first `out_ready=1`.
- With `count=3`, assert `flush` together with a push → next cycle `count=0`, `out_valid=0`, and the pushed entry is lost. A `rst` asserted mid-stream gives the same result plus all outputs at 0.
